// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register map, edge-mode encodings and
// the data-bus width, plus a helper that sizes the debounce counter.
package gpio_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        REG_IN   = 2'd0,
        REG_OUT  = 2'd1,
        REG_PEND = 2'd2,
        REG_MASK = 2'd3
    } reg_addr_e;

    typedef enum int {
        EDGE_RISE = 0,
        EDGE_FALL = 1,
        EDGE_BOTH = 2
    } edge_mode_e;

    // The counter only has to reach DEBOUNCE_CYCLES-1 before the accept fires.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: 2-flop synchroniser, saturating debounce counter,
// accepted stable level and a one-cycle pulse on the selected edge.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int EDGE_MODE       = EDGE_RISE
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic pin,
    output logic stable,
    output logic edge_pulse
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] count;

    // NOTE: non-blocking assignments so every flop samples pre-edge values and the chain shifts one stage per clock.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable_q <= 1'b0;
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            sync1    <= pin;
            sync2    <= sync1;
            stable_d <= stable_q;
            if (sync2 == stable_q) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // Accepting on the last count means the counter can never wrap.
                stable_q <= sync2;
                count    <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign stable = stable_q;

    always_comb begin
        // NOTE: assign a default first so no path leaves edge_pulse unassigned and infers a latch.
        edge_pulse = 1'b0;
        case (EDGE_MODE)
            EDGE_FALL: edge_pulse = ~stable_q & stable_d;
            EDGE_BOTH: edge_pulse = stable_q ^ stable_d;
            default:   edge_pulse = stable_q & ~stable_d;
        endcase
    end

endmodule

// File: rtl/gpio_bank.sv
// Register-mapped GPIO bank: debounced inputs with edge-pending capture,
// latched outputs, a maskable registered interrupt and a registered read port.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int IN_WIDTH        = 4,
    parameter int OUT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int EDGE_MODE       = EDGE_RISE
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [IN_WIDTH-1:0]  PIN_IN,
    output logic [OUT_WIDTH-1:0] PIN_OUT,
    input  logic [1:0]           ADDR,
    input  logic [DATA_W-1:0]    DIN,
    output logic [DATA_W-1:0]    DOUT,
    input  logic                 RD,
    input  logic                 WR,
    output logic                 IRQ
);

    reg_addr_e            addr;
    logic [IN_WIDTH-1:0]  stable;
    logic [IN_WIDTH-1:0]  edge_hit;
    logic [IN_WIDTH-1:0]  pend_q;
    logic [IN_WIDTH-1:0]  mask_q;
    logic [IN_WIDTH-1:0]  w1c;
    logic [OUT_WIDTH-1:0] out_q;
    logic [DATA_W-1:0]    rd_data;
    logic                 irq_q;

    assign addr = reg_addr_e'(ADDR);

    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_ch
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE)
        ) u_debounce (
            .CLK       (CLK),
            .RESETN    (RESETN),
            .pin       (PIN_IN[i]),
            .stable    (stable[i]),
            .edge_pulse(edge_hit[i])
        );
    end

    assign w1c = (WR && addr == REG_PEND) ? DIN[IN_WIDTH-1:0] : '0;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            out_q  <= '0;
            mask_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
            DOUT   <= '0;
        end else begin
            if (WR && addr == REG_OUT)  out_q  <= DIN[OUT_WIDTH-1:0];
            if (WR && addr == REG_MASK) mask_q <= DIN[IN_WIDTH-1:0];
            // A new edge in the same cycle as a clear keeps the bit set.
            pend_q <= (pend_q & ~w1c) | edge_hit;
            irq_q  <= |(pend_q & mask_q);
            if (RD) DOUT <= rd_data;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_IN:   rd_data[IN_WIDTH-1:0]  = stable;
            REG_OUT:  rd_data[OUT_WIDTH-1:0] = out_q;
            REG_PEND: rd_data[IN_WIDTH-1:0]  = pend_q;
            REG_MASK: rd_data[IN_WIDTH-1:0]  = mask_q;
            default:  rd_data = '0;
        endcase
    end

    assign PIN_OUT = out_q;
    assign IRQ     = irq_q;

    // DIN bits above the widest register are ignored by design.
    logic unused_din;
    assign unused_din = ^DIN;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: reads push expected DOUT into a queue that a
// monitor drains on the cycle after each read; pins and IRQ are checked inline.
module tb_gpio_bank;
    import gpio_pkg::*;

    logic        CLK    = 1'b0;
    logic        RESETN = 1'b0;
    logic [3:0]  PIN_IN = '0;
    logic [1:0]  ADDR   = '0;
    logic [15:0] DIN    = '0;
    logic        RD     = 1'b0;
    logic        WR     = 1'b0;

    logic [7:0]  pin_out_a, pin_out_b;
    logic [15:0] dout_a, dout_b;
    logic        irq_a, irq_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          dut;
        logic [15:0] exp_v;
        string       name;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;
    logic    rd_q = 1'b0;

    always #5 CLK = ~CLK;

    gpio_bank #(
        .IN_WIDTH(4), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)
    ) u_dut_a (
        .CLK(CLK), .RESETN(RESETN), .PIN_IN(PIN_IN), .PIN_OUT(pin_out_a),
        .ADDR(ADDR), .DIN(DIN), .DOUT(dout_a), .RD(RD), .WR(WR), .IRQ(irq_a)
    );

    gpio_bank #(
        .IN_WIDTH(4), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)
    ) u_dut_b (
        .CLK(CLK), .RESETN(RESETN), .PIN_IN(PIN_IN), .PIN_OUT(pin_out_b),
        .ADDR(ADDR), .DIN(DIN), .DOUT(dout_b), .RD(RD), .WR(WR), .IRQ(irq_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: DOUT is valid on the cycle after an edge that saw RD=1.
    always @(posedge CLK) rd_q <= RD;

    always @(negedge CLK) begin
        if (rd_q) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%04h expected no read at %0t", dout_a, $time);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.name, (mon_e.dut == 0) ? dout_a : dout_b, mon_e.exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_read(input int dut, input logic [1:0] a, input logic [15:0] exp_v,
                           input string name);
        rd_exp_t e;
        e = '{dut, exp_v, name};
        sb.push_back(e);
        ADDR = a;
        RD   = 1'b1;
        tick();
        RD   = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        ADDR = a;
        DIN  = d;
        WR   = 1'b1;
        tick();
        WR   = 1'b0;
    endtask

    task automatic do_rw(input logic [1:0] a, input logic [15:0] d, input logic [15:0] exp_v,
                         input string name);
        rd_exp_t e;
        e = '{0, exp_v, name};
        sb.push_back(e);
        ADDR = a;
        DIN  = d;
        RD   = 1'b1;
        WR   = 1'b1;
        tick();
        RD   = 1'b0;
        WR   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) tick();
        RESETN = 1'b1;
        tick();

        // Reset state
        check("rst_pin_out", {8'h00, pin_out_a}, 16'h0000);
        check("rst_irq", {15'h0, irq_a}, 16'h0000);
        do_read(0, REG_PEND, 16'h0000, "rst_pend");
        do_read(0, REG_MASK, 16'h0000, "rst_mask");

        // 1. Reset mid-run, then register write/readback
        do_write(REG_OUT, 16'h0033);
        do_read(0, REG_OUT, 16'h0033, "out_pre_reset");
        tick();
        RESETN = 1'b0;
        #1;
        check("async_rst_dout", dout_a, 16'h0000);
        check("async_rst_irq", {15'h0, irq_a}, 16'h0000);
        check("async_rst_pin_out", {8'h00, pin_out_a}, 16'h0000);
        #2;
        RESETN = 1'b1;
        tick();
        ADDR = REG_OUT;
        DIN  = 16'h00A5;
        WR   = 1'b1;
        check("pin_out_before_wr_edge", {8'h00, pin_out_a}, 16'h0000);
        tick();
        WR = 1'b0;
        check("pin_out_on_wr_edge", {8'h00, pin_out_a}, 16'h00A5);
        do_read(0, REG_OUT, 16'h00A5, "out_readback");
        do_rw(REG_OUT, 16'h005A, 16'h00A5, "rw_overlap_prewrite");
        check("pin_out_after_rw", {8'h00, pin_out_a}, 16'h005A);
        do_read(0, REG_OUT, 16'h005A, "out_after_rw");
        do_write(REG_MASK, 16'hFFFF);
        do_read(0, REG_MASK, 16'h000F, "mask_high_bits_zero");
        do_write(REG_MASK, 16'h0000);
        do_write(REG_OUT, 16'hFF3C);
        do_read(0, REG_OUT, 16'h003C, "out_high_bits_zero");

        // 2. Debounce accept on channel 0: stable after edge 6, pending at edge 7
        PIN_IN[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 5)      do_read(0, REG_IN, 16'h0000, "in_before_accept");
            else if (k == 6) tick();
            else if (k == 7) do_read(0, REG_PEND, 16'h0000, "pend_before_edge7");
            else if (k == 8) do_read(0, REG_PEND, 16'h0001, "pend_set_edge7");
            else             do_read(0, REG_IN, 16'h0001, "in_accepted");
        end
        do_write(REG_PEND, 16'h0001);
        do_read(0, REG_PEND, 16'h0000, "pend_w1c");
        PIN_IN[0] = 1'b0;
        repeat (8) tick();
        do_read(0, REG_IN, 16'h0000, "in_fall_accepted");
        do_read(0, REG_PEND, 16'h0000, "rise_mode_ignores_fall");
        do_write(REG_PEND, 16'h000F);

        // 3. Glitch of 3 cycles on channel 1 is rejected
        PIN_IN[1] = 1'b1;
        repeat (3) do_read(0, REG_IN, 16'h0000, "in_during_glitch");
        PIN_IN[1] = 1'b0;
        repeat (8) tick();
        do_read(0, REG_IN, 16'h0000, "in_after_glitch");
        do_read(0, REG_PEND, 16'h0000, "pend_after_glitch");

        // 4. Interrupt and write-1-to-clear
        do_write(REG_MASK, 16'h0001);
        PIN_IN[0] = 1'b1;
        repeat (7) tick();
        check("irq_low_at_pend_edge", {15'h0, irq_a}, 16'h0000);
        tick();
        check("irq_high_after_pend", {15'h0, irq_a}, 16'h0001);
        do_write(REG_PEND, 16'h0000);
        check("irq_after_w0", {15'h0, irq_a}, 16'h0001);
        do_read(0, REG_PEND, 16'h0001, "pend_w0_noop");
        do_write(REG_PEND, 16'h0001);
        check("irq_hold_on_w1c_edge", {15'h0, irq_a}, 16'h0001);
        tick();
        check("irq_drop_after_w1c", {15'h0, irq_a}, 16'h0000);
        do_write(REG_MASK, 16'h0000);

        // 5. Set wins over a coincident clear on channel 2
        PIN_IN[2] = 1'b1;
        repeat (6) tick();
        do_write(REG_PEND, 16'h0004);
        do_read(0, REG_PEND, 16'h0004, "set_wins_collision");
        do_write(REG_PEND, 16'h0004);
        do_read(0, REG_PEND, 16'h0000, "pend_clear_after_collision");

        // Reset with inputs held high: re-accepted as rising edges
        RESETN = 1'b0;
        #3;
        RESETN = 1'b1;
        repeat (7) tick();
        do_read(0, REG_PEND, 16'h0005, "reaccept_pend");
        do_read(0, REG_IN, 16'h0005, "reaccept_in");
        check("reaccept_pin_out", {8'h00, pin_out_a}, 16'h0000);
        PIN_IN = 4'h0;
        repeat (8) tick();
        do_write(REG_PEND, 16'h000F);

        // 6. Both-edge mode on channel 3 with the mask off
        PIN_IN[3] = 1'b1;
        repeat (7) tick();
        do_read(1, REG_PEND, 16'h0008, "both_rise_pend");
        check("both_rise_irq_masked", {15'h0, irq_b}, 16'h0000);
        do_write(REG_PEND, 16'h0008);
        PIN_IN[3] = 1'b0;
        repeat (7) tick();
        do_read(1, REG_PEND, 16'h0008, "both_fall_pend");
        do_read(0, REG_PEND, 16'h0000, "rise_only_no_fall_pend");
        check("both_fall_irq_masked", {15'h0, irq_b}, 16'h0000);
        do_write(REG_MASK, 16'h0008);
        check("irq_on_unmask_edge", {15'h0, irq_b}, 16'h0000);
        tick();
        check("irq_after_unmask", {15'h0, irq_b}, 16'h0001);

        repeat (2) tick();
        check("scoreboard_drained", 16'(sb.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised successor to the dev-board GPIO block: a register-mapped bank of debounced inputs and latched outputs, with per-channel edge detection and a maskable interrupt. It sits between the CPU I/O decode (RD/WR/ADDR strobes) and the board pins (DIP switches, pushbuttons, LEDs). It adds what the first generation lacked: configurable widths, input synchronisation and debounce, edge-pending capture with write-1-to-clear, and an interrupt output.

Parameters:
IN_WIDTH, 4, number of input channels (1..16)
OUT_WIDTH, 8, number of output channels (1..16)
DEBOUNCE_CYCLES, 12000, consecutive stable cycles required to accept an input change (1 ms at 12 MHz); 1 = no debounce
EDGE_MODE, 0, edge that sets pending: 0 rising, 1 falling, 2 both

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
PIN_IN  in  IN_WIDTH  raw asynchronous input pins
PIN_OUT  out  OUT_WIDTH  output register to pins
ADDR  in  2  register select
DIN  in  16  write data from CPU
DOUT  out  16  registered read data
RD  in  1  read strobe, one cycle
WR  in  1  write strobe, one cycle
IRQ  out  1  registered interrupt request, active high

Behaviour:
- Clocking: one clock, CLK; reset is asynchronous and active-low on RESETN. All flops are on posedge CLK and cleared on negedge RESETN.
- Reset values: PIN_OUT=0, DOUT=0, IRQ=0, pending=0, mask=0, sync flops=0, stable=0, debounce counters=0.
- Register map (16-bit, unused high bits read 0 and ignore writes):
  - 0 IN: debounced stable value, read-only.
  - 1 OUT: read/write, drives PIN_OUT.
  - 2 PEND: edge-pending bits; writing 1 clears a bit, writing 0 has no effect.
  - 3 MASK: interrupt enables, read/write.
- Read path: DOUT is loaded on the edge where RD=1 with the register selected by ADDR, giving one-cycle latency. DOUT holds its value when RD=0.
- Read/write overlap: RD and WR in the same cycle to the same address returns the pre-write value.
- Write path: on an edge where WR=1 the target register updates, and PIN_OUT changes on that edge.
- Input pipeline, per channel:
  - A 2-flop synchroniser feeds the debouncer.
  - The counter increments on each edge where the synchroniser output differs from stable.
  - The counter clears on any edge where they match.
  - On the DEBOUNCE_CYCLES-th consecutive mismatched edge, stable takes the synchroniser value and the counter clears.
  - Total latency from a pin change to the IN register is 2+DEBOUNCE_CYCLES edges.
  - Pulses shorter than DEBOUNCE_CYCLES cycles after synchronisation are discarded.
  - The counter saturates; it never wraps.
- Edge detect: pending[i] is set on the edge after stable[i] makes a transition that matches EDGE_MODE.
- Set/clear collision: if a set and a W1C for the same bit occur in the same cycle, the set wins.
- IRQ: registered as OR(pending & mask), asserted one edge after pending or mask changes. Clearing the last masked pending bit drops IRQ one edge later.
- Mask behaviour: mask does not gate pending capture, so bits pend while masked. Unmasking a pending bit raises IRQ.
- Reset mid-debounce: the counter and stable clear. An input that is held high after reset is re-accepted after 2+DEBOUNCE_CYCLES edges, which sets a rising pending.

Decomposition:
- gpio_pkg holds:
  - Register address constants: REG_IN=0, REG_OUT=1, REG_PEND=2, REG_MASK=3.
  - EDGE_MODE encodings: EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - DATA_W=16.
- Sub-module gpio_debounce is a single channel (synchroniser, counter, stable, edge pulse output), parametrised by DEBOUNCE_CYCLES and EDGE_MODE. It is instantiated IN_WIDTH times by generate.
- The top level holds the register file, the read mux and the IRQ logic.

Test Plan (DEBOUNCE_CYCLES=4, IN_WIDTH=4, OUT_WIDTH=8, EDGE_MODE=0 unless stated):
1. Reset and registers: pulse RESETN low mid-run, then write 0x00A5 to OUT. PIN_OUT=0xA5 on the write edge; reading OUT gives DOUT=0x00A5 one cycle later; DOUT=0, IRQ=0 and PIN_OUT=0 immediately on reset assert.
2. Debounce accept: set PIN_IN[0] from 0 to 1 and hold. A read of IN returns 0x0001 only from edge 6 after the change; PEND bit 0 is set at edge 7.
3. Glitch reject: pulse PIN_IN[1] high for 3 cycles. IN stays 0x0000 and PEND stays 0x0000.
4. Interrupt and W1C: write MASK=0x0001, then produce a rising edge on channel 0. IRQ rises one edge after pending; writing PEND=0x0001 drops IRQ one edge later; writing PEND=0x0000 has no effect.
5. Set-wins collision: time a PEND W1C for bit 2 to coincide with a new stable rising edge on channel 2. PEND bit 2 reads 1 afterwards.
6. EDGE_MODE=2 with masked pend: toggle channel 3 up then down with MASK=0. PEND bit 3 is set on each edge and IRQ stays 0; writing MASK=0x0008 raises IRQ one edge later.
